// File: rtl/sw_debounce_pkg.sv
// -----------------------------------------------------------------------------
// sw_debounce_pkg
//   Shared constants for the switch debounce / hex presentation block.
//   NUM_SW      : number of raw slide switches (one hex nibble)
//   DIGIT_W     : width of one display digit
//   NUM_DIGITS  : digits held in the display history word
//   cnt_width() : width of the per-switch run counter for a given
//                 DEBOUNCE_CYCLES, wide enough to hold DEBOUNCE_CYCLES.
// -----------------------------------------------------------------------------
package sw_debounce_pkg;

  localparam int NUM_SW     = 4;
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  function automatic int cnt_width(input int cycles);
    // Degenerate small values still get a 1-bit counter.
    if (cycles <= 1) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_cell.sv
// -----------------------------------------------------------------------------
// sw_debounce_cell
//   Conditions one raw switch: two-flop synchroniser (s1, s2), a run counter
//   that measures how long s2 has disagreed with the accepted level, and the
//   accepted (stable) level itself.
//
//   Parameters
//     DEBOUNCE_CYCLES : synchronised cycles a new level must persist (>= 1)
//   Ports
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     sw_raw     in   raw asynchronous switch level
//     stab       out  accepted level (registered)
//     stab_next  out  level stab takes on the next edge
//     accept     out  high in the cycle whose edge flips stab
// -----------------------------------------------------------------------------
module sw_debounce_cell
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic stab,
  output logic stab_next,
  output logic accept
);

  localparam int            CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q,   s1_d;
  logic             s2_q,   s2_d;
  logic             stab_q, stab_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // leaves a value unassigned, which would otherwise infer a latch.
    s1_d   = sw_raw;
    s2_d   = s1_q;
    stab_d = stab_q;
    cnt_d  = cnt_q;
    accept = 1'b0;

    if (s2_q == stab_q) begin
      // Any return to the accepted level restarts the run.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Counter saturates here by construction: it never passes CNT_LAST.
      stab_d = s2_q;
      cnt_d  = '0;
      accept = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      stab_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its neighbours; blocking here would collapse the
      // synchroniser into a single stage.
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      stab_q <= stab_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stab      = stab_q;
  assign stab_next = stab_d;

endmodule : sw_debounce_cell

// File: rtl/sw_debounce_hex.sv
// -----------------------------------------------------------------------------
// sw_debounce_hex
//   Synchronises and debounces four slide switches and presents a clean hex
//   nibble, a one-cycle change strobe and a four-digit display word for the
//   seven-segment multiplexer.
//
//   Build option: define SW_DEBOUNCE_HISTORY_EN to keep a shift register of
//   the last four accepted values in digits; otherwise digits carries only the
//   current value in its rightmost nibble.
//
//   Parameters
//     DEBOUNCE_CYCLES : synchronised cycles a switch must hold (>= 1)
//   Ports
//     clk         in   system clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     sw0..sw3    in   raw switch levels, sw3 is the MSB
//     sw_val      out  debounced {sw3,sw2,sw1,sw0}
//     sw_changed  out  one-cycle pulse aligned with each new sw_val
//     digits      out  display word, digits[3:0] is the rightmost digit
// -----------------------------------------------------------------------------
module sw_debounce_hex
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sw0,
  input  logic                          sw1,
  input  logic                          sw2,
  input  logic                          sw3,
  output logic [NUM_SW-1:0]             sw_val,
  output logic                          sw_changed,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits
);

  localparam int HIST_W = NUM_DIGITS * DIGIT_W;

  logic [NUM_SW-1:0] sw_raw;
  logic [NUM_SW-1:0] stab;
  logic [NUM_SW-1:0] stab_next;
  logic [NUM_SW-1:0] accept;

  assign sw_raw = {sw3, sw2, sw1, sw0};

  for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
    sw_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_raw   (sw_raw[i]),
      .stab     (stab[i]),
      .stab_next(stab_next[i]),
      .accept   (accept[i])
    );
  end

  // The strobe is registered from the accept terms so it rises on the same
  // edge as the new stab bits; simultaneous flips merge into one pulse.
  logic sw_changed_q, sw_changed_d;

  always_comb begin
    sw_changed_d = |accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_changed_q <= 1'b0;
    else        sw_changed_q <= sw_changed_d;
  end

  assign sw_val     = stab;
  assign sw_changed = sw_changed_q;

`ifdef SW_DEBOUNCE_HISTORY_EN
  // Shift on the same edge stab updates, using the incoming value, so digits
  // already shows the new nibble while sw_changed is high.
  logic [HIST_W-1:0] digits_q, digits_d;

  always_comb begin
    digits_d = digits_q;
    if (|accept) digits_d = {digits_q[HIST_W-DIGIT_W-1:0], stab_next};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digits_q <= '0;
    else        digits_q <= digits_d;
  end

  assign digits = digits_q;
`else
  assign digits = {{(HIST_W - NUM_SW){1'b0}}, stab};
`endif

endmodule : sw_debounce_hex
